// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle synchronous imem
// and buffers {pc, inst} pairs in a small FIFO drained by decode.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_branch, i_jump  redirect requests (ORed), target in i_target
//   o_imem_req        imem read strobe, address o_imem_raddr
//   i_imem_rdata      imem data, valid the cycle after o_imem_req
//   o_valid, o_inst,  FIFO head toward decode
//   o_pc, i_ready     pop when o_valid & i_ready
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic [31:0] i_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [0:0]    state;
    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_addr;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] tail;

    logic [31:0] buf_pc   [DEPTH];
    logic [31:0] buf_inst [DEPTH];

    logic        run;
    logic        redirect;
    logic        pop;
    logic        push;
    logic        space;
    logic [31:0] tgt;
    logic [CW:0] credit;
    logic [CW:0] tail_sum;

    always_comb begin
        run      = (state == RUN);
        redirect = run & (i_branch | i_jump);
        tgt      = i_target & 32'hFFFF_FFFC;

        o_valid  = (count != '0) & ~redirect;
        pop      = o_valid & i_ready;

        // Count words already owed to the FIFO so a stalled decode
        // can never cause the returning read to overflow it.
        credit = {1'b0, count}
               + (CW + 1)'(inflight)
               - (CW + 1)'(pop);
        space  = credit < DEPTH_W;

        o_imem_req   = run & (redirect | space);
        o_imem_raddr = redirect ? tgt : pc;

        // A response arriving in a redirect cycle is wrong-path.
        push = inflight & ~redirect;

        head_nxt = (head == LAST) ? '0 : head + PW'(1);

        tail_sum = (CW + 1)'(head) + {1'b0, count};
        if (tail_sum >= DEPTH_W) begin
            tail_sum = tail_sum - DEPTH_W;
        end
        tail = tail_sum[PW-1:0];

        o_pc   = 32'h0;
        o_inst = 32'h0;
        if (count != '0) begin
            o_pc   = buf_pc[head];
            o_inst = buf_inst[head];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            pc            <= RESET_ADDR;
            inflight      <= 1'b0;
            inflight_addr <= 32'h0;
            count         <= '0;
            head          <= '0;
        end else begin
            state    <= RUN;
            inflight <= o_imem_req;
            if (o_imem_req) begin
                pc            <= o_imem_raddr + 32'd4;
                inflight_addr <= o_imem_raddr;
            end
            if (redirect) begin
                count <= '0;
            end else begin
                if (pop) begin
                    head <= head_nxt;
                end
                if (push & ~pop) begin
                    count <= count + CW'(1);
                end else if (pop & ~push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (~i_rst & push) begin
            buf_pc[tail]   <= inflight_addr;
            buf_inst[tail] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table plus hand-written
// stall/redirect-while-full sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata = 32'h0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ready = 1'b1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_ADDR(32'h0000_0000),
        .DEPTH(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_branch(branch),
        .i_jump(jump),
        .i_target(target),
        .o_imem_req(imem_req),
        .o_imem_raddr(imem_raddr),
        .i_imem_rdata(imem_rdata),
        .o_valid(valid),
        .o_inst(inst),
        .o_pc(pc),
        .i_ready(ready)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata <= mem_word(imem_raddr);
        end
    end

    typedef struct {
        logic        rst;
        logic        br;
        logic        jmp;
        logic [31:0] tgt;
        logic        rdy;
        logic        req;
        logic [31:0] raddr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[$];

    task automatic add(
        input logic        r,
        input logic        b,
        input logic        j,
        input logic [31:0] t,
        input logic        y,
        input logic        q,
        input logic [31:0] a,
        input logic        v,
        input logic [31:0] p
    );
        vt.push_back('{r, b, j, t, y, q, a, v, p});
    endtask

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(
        input string       tag,
        input logic        q,
        input logic [31:0] a,
        input logic        v,
        input logic [31:0] p
    );
        chk({tag, " req"}, 32'(imem_req), 32'(q));
        if (q) begin
            chk({tag, " raddr"}, imem_raddr, a);
        end
        chk({tag, " valid"}, 32'(valid), 32'(v));
        if (v) begin
            chk({tag, " pc"}, pc, p);
            chk({tag, " inst"}, inst, mem_word(p));
        end
    endtask

    task automatic drive(
        input logic        r,
        input logic        b,
        input logic        j,
        input logic [31:0] t,
        input logic        y
    );
        @(negedge clk);
        rst    = r;
        branch = b;
        jump   = j;
        target = t;
        ready  = y;
        #1;
    endtask

    initial begin
        // reset with a branch held high, then a branch in IDLE
        add(1, 1, 0, 32'h40, 1,  0, 32'h0, 0, 32'h0);
        add(0, 1, 0, 32'h40, 1,  0, 32'h0, 0, 32'h0);
        // sequential fetch from RESET_ADDR
        add(0, 0, 0, 32'h0, 1,  1, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0, 1,  1, 32'h4,  0, 32'h0);
        add(0, 0, 0, 32'h0, 1,  1, 32'h8,  1, 32'h0);
        add(0, 0, 0, 32'h0, 1,  1, 32'hC,  1, 32'h4);
        add(0, 0, 0, 32'h0, 1,  1, 32'h10, 1, 32'h8);
        // five-cycle decode stall
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 0, 32'h0, 0,  0, 32'h14, 1, 32'hC);
        end
        add(0, 0, 0, 32'h0, 1,  1, 32'h14, 1, 32'hC);
        add(0, 0, 0, 32'h0, 1,  1, 32'h18, 1, 32'h10);
        add(0, 0, 0, 32'h0, 1,  1, 32'h1C, 1, 32'h14);
        // branch to misaligned 0x103
        add(0, 1, 0, 32'h103, 1,  1, 32'h100, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1,  1, 32'h104, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1,  1, 32'h108, 1, 32'h100);
        add(0, 0, 0, 32'h0,   1,  1, 32'h10C, 1, 32'h104);
        // jump then branch back-to-back
        add(0, 0, 1, 32'h200, 1,  1, 32'h200, 0, 32'h0);
        add(0, 1, 0, 32'h300, 1,  1, 32'h300, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1,  1, 32'h304, 0, 32'h0);
        add(0, 0, 0, 32'h0,   1,  1, 32'h308, 1, 32'h300);
        // PC wrap at top of address space
        add(0, 0, 1, 32'hFFFF_FFF8, 1,  1, 32'hFFFF_FFF8, 0, 32'h0);
        add(0, 0, 0, 32'h0, 1,  1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 0, 0, 32'h0, 1,  1, 32'h0, 1, 32'hFFFF_FFF8);
        add(0, 0, 0, 32'h0, 1,  1, 32'h4, 1, 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0, 1,  1, 32'h8, 1, 32'h0);

        // initial reset and reset-state check
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst req", 32'(imem_req), 32'h0);
        chk("rst valid", 32'(valid), 32'h0);
        chk("rst pc", pc, 32'h0);
        chk("rst inst", inst, 32'h0);

        foreach (vt[k]) begin
            drive(vt[k].rst, vt[k].br, vt[k].jmp,
                  vt[k].tgt, vt[k].rdy);
            check_out($sformatf("v%0d", k), vt[k].req,
                      vt[k].raddr, vt[k].valid, vt[k].pc);
        end

        // fill the FIFO under stall, then redirect while full
        drive(0, 0, 0, 32'h0, 0);
        check_out("full0", 0, 32'hC, 1, 32'h4);
        drive(0, 0, 0, 32'h0, 0);
        check_out("full1", 0, 32'hC, 1, 32'h4);
        drive(0, 1, 0, 32'h502, 0);
        check_out("fullbr", 1, 32'h500, 0, 32'h0);
        drive(0, 0, 0, 32'h0, 1);
        check_out("fullbr1", 1, 32'h504, 0, 32'h0);
        drive(0, 0, 0, 32'h0, 1);
        check_out("fullbr2", 1, 32'h508, 1, 32'h500);
        drive(0, 0, 0, 32'h0, 1);
        check_out("fullbr3", 1, 32'h50C, 1, 32'h504);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
